// File: rtl/multi_gate_tester_pkg.sv
// multi_gate_tester_pkg: gate function codes, FSM states and the reference gate function.
package multi_gate_tester_pkg;
    localparam logic [2:0] FN_AND = 3'd0, FN_OR = 3'd1, FN_NAND = 3'd2, FN_NOR = 3'd3,
                           FN_XOR = 3'd4, FN_XNOR = 3'd5, FN_NOT = 3'd6, FN_INVALID = 3'd7;

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    // Reduces the low n bits of vec; NOT looks only at bit 0.
    function automatic logic expected_out(input logic [2:0] func, input logic [3:0] vec, input int n);
        logic a, o, x;
        a = 1'b1;
        o = 1'b0;
        x = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i < n) begin
                a &= vec[i];
                o |= vec[i];
                x ^= vec[i];
            end
        return func == FN_AND  ? a :
               func == FN_OR   ? o :
               func == FN_NAND ? ~a :
               func == FN_NOR  ? ~o :
               func == FN_XOR  ? x :
               func == FN_XNOR ? ~x :
               func == FN_NOT  ? ~vec[0] : 1'b0;
    endfunction
endpackage

// File: rtl/multi_gate_tester_if.sv
// multi_gate_tester_if: control and result bus between the IC decoder/LEDs and the tester.
interface multi_gate_tester_if #(parameter int NUM_GATES = 4);
    logic                 start;
    logic [2:0]           gate_func;
    logic [NUM_GATES-1:0] gate_en;
    logic [NUM_GATES-1:0] gate_pass;
    logic [NUM_GATES-1:0] gate_fail;
    logic                 pass;
    logic                 fail;
    logic                 busy;
    logic                 done;

    modport master (output start, gate_func, gate_en,
                    input gate_pass, gate_fail, pass, fail, busy, done);
    modport slave  (input start, gate_func, gate_en,
                    output gate_pass, gate_fail, pass, fail, busy, done);
endinterface

// File: rtl/multi_gate_tester_ref.sv
// multi_gate_tester_ref: combinational expected gate output for one input vector.
module multi_gate_tester_ref
    import multi_gate_tester_pkg::*;
#(
    parameter int GATE_INPUTS = 2
) (
    input  logic [2:0]             func,
    input  logic [GATE_INPUTS-1:0] vec,
    output logic                   exp_out
);
    assign exp_out = expected_out(func, 4'(vec), GATE_INPUTS);
endmodule

// File: rtl/multi_gate_tester.sv
// multi_gate_tester: steps every input vector through NUM_GATES gates, waits, samples
// the synchronised outputs against the reference and reports per-gate and overall results.
module multi_gate_tester
    import multi_gate_tester_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int GATE_INPUTS   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    multi_gate_tester_if.slave               bus,
    output logic [NUM_GATES*GATE_INPUTS-1:0] dut_in,
    input  logic [NUM_GATES-1:0]             dut_out
);
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [GATE_INPUTS:0] LAST = (GATE_INPUTS + 1)'(2 ** GATE_INPUTS - 1);

    state_t               state, state_n;
    logic [GATE_INPUTS:0] vec;
    logic [CW-1:0]        cnt;
    logic [2:0]           func;
    logic [NUM_GATES-1:0] en, sticky, sticky_n, sync1, sync2, gate_pass, gate_fail;
    logic                 pass, fail, done, exp_out, last, settled;

    multi_gate_tester_ref #(.GATE_INPUTS(GATE_INPUTS)) ref_model (
        .func    (func),
        .vec     (vec[GATE_INPUTS-1:0]),
        .exp_out (exp_out)
    );

    assign last     = vec == LAST;
    assign settled  = cnt == CW'(SETTLE_CYCLES - 1);
    assign sticky_n = sticky | ((sync2 ^ {NUM_GATES{exp_out}}) & en);

    assign bus.gate_pass = gate_pass;
    assign bus.gate_fail = gate_fail;
    assign bus.pass      = pass;
    assign bus.fail      = fail;
    assign bus.done      = done;
    assign bus.busy      = state inside {APPLY, SETTLE, SAMPLE};

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (bus.start) state_n = bus.gate_func == FN_INVALID ? DONE : APPLY;
            APPLY:      state_n = SETTLE;
            SETTLE:     if (settled) state_n = SAMPLE;
            SAMPLE:     state_n = last ? DONE : APPLY;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in    <= '0;
            gate_pass <= '0;
            gate_fail <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            done      <= 1'b0;
            sync1     <= '0;
            sync2     <= '0;
            vec       <= '0;
            cnt       <= '0;
            func      <= '0;
            en        <= '0;
            sticky    <= '0;
        end else begin
            sync1 <= dut_out;
            sync2 <= sync1;
            case (state)
                IDLE, DONE:
                    if (bus.start) begin
                        func      <= bus.gate_func;
                        en        <= bus.gate_en;
                        sticky    <= '0;
                        vec       <= '0;
                        done      <= 1'b0;
                        gate_pass <= '0;
                        gate_fail <= bus.gate_func == FN_INVALID ? bus.gate_en : '0;
                        pass      <= 1'b0;
                        fail      <= bus.gate_func == FN_INVALID;
                    end else if (state == DONE) begin
                        // An invalid-function start parks here with done low for one clock.
                        done <= 1'b1;
                    end
                APPLY: begin
                    dut_in <= {NUM_GATES{vec[GATE_INPUTS-1:0]}};
                    cnt    <= '0;
                end
                SETTLE: cnt <= cnt + 1'b1;
                SAMPLE: begin
                    sticky <= sticky_n;
                    if (last) begin
                        dut_in    <= '0;
                        gate_fail <= sticky_n & en;
                        gate_pass <= ~sticky_n & en;
                        fail      <= |(sticky_n & en);
                        pass      <= (|en) & ~(|(sticky_n & en));
                        done      <= 1'b1;
                    end else begin
                        vec <= vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_gate_tester.sv
// tb_multi_gate_tester: scoreboard bench; a behavioural chip model answers dut_in, expected
// results are queued at each start and checked by a monitor on every rising done.
module tb_multi_gate_tester;
    import multi_gate_tester_pkg::*;

    localparam int NG = 4, GI = 2;

    typedef struct {
        logic [3:0] gp;
        logic [3:0] gf;
        logic       p;
        logic       f;
        int         lat;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic [NG*GI-1:0] dut_in;
    logic [NG-1:0] dut_out;
    logic [2:0]    model_func = 3'd0;
    logic [3:0]    stuck0 = 4'h0, rnd_mask = 4'h0, rnd = 4'h0;
    exp_t          q[$];
    int            errors = 0, checks = 0, cyc = 0, start_cyc = 0;

    multi_gate_tester_if #(.NUM_GATES(NG)) bus ();

    multi_gate_tester #(.NUM_GATES(NG), .GATE_INPUTS(GI), .SETTLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .dut_in  (dut_in),
        .dut_out (dut_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rnd <= 4'($urandom);
    end

    function automatic logic chip(input logic [2:0] f, input logic [1:0] v);
        case (f)
            3'd0:    return v[0] & v[1];
            3'd1:    return v[0] | v[1];
            3'd2:    return ~(v[0] & v[1]);
            3'd3:    return ~(v[0] | v[1]);
            3'd4:    return v[0] ^ v[1];
            3'd5:    return ~(v[0] ^ v[1]);
            3'd6:    return ~v[0];
            default: return 1'b0;
        endcase
    endfunction

    always_comb
        for (int g = 0; g < NG; g++)
            dut_out[g] = stuck0[g] ? 1'b0 : rnd_mask[g] ? rnd[g] : chip(model_func, dut_in[g*GI +: GI]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic run(input logic [2:0] f, input logic [3:0] en, input exp_t e, input bit push);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.gate_func = f;
        bus.gate_en   = en;
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        check("done_timeout", q.size(), 0);
        q.delete();
        @(negedge clk);
    endtask

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !prev) begin
                if (q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    e = q.pop_front();
                    check("gate_pass", bus.gate_pass, e.gp);
                    check("gate_fail", bus.gate_fail, e.gf);
                    check("pass", bus.pass, e.p);
                    check("fail", bus.fail, e.f);
                    check("latency", cyc - start_cyc, e.lat);
                end
            end
            prev = bus.done;
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.gate_func = 3'd0;
        bus.gate_en   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dut_in", dut_in, 0);
        check("rst_results", {bus.gate_pass, bus.gate_fail, bus.pass, bus.fail}, 0);
        check("rst_busy_done", {bus.busy, bus.done}, 0);
        @(negedge clk);
        rst = 1'b0;

        model_func = FN_AND;
        run(FN_AND, 4'hF, '{4'hF, 4'h0, 1'b1, 1'b0, 24}, 1);
        check("busy_in_run", bus.busy, 1);
        wait_idle();
        check("busy_after_done", bus.busy, 0);
        check("dut_in_after_done", dut_in, 0);

        model_func = FN_NAND;
        stuck0 = 4'b0100;
        run(FN_NAND, 4'hF, '{4'b1011, 4'b0100, 1'b0, 1'b1, 24}, 1);
        wait_idle();
        stuck0 = 4'h0;

        model_func = FN_NOT;
        rnd_mask = 4'b1100;
        run(FN_NOT, 4'b0011, '{4'b0011, 4'h0, 1'b1, 1'b0, 24}, 1);
        wait_idle();
        rnd_mask = 4'h0;

        run(FN_INVALID, 4'b1010, '{4'h0, 4'b1010, 1'b0, 1'b1, 1}, 1);
        check("invalid_busy", bus.busy, 0);
        check("invalid_dut_in", dut_in, 0);
        wait_idle();
        check("invalid_dut_in_done", dut_in, 0);

        model_func = FN_XOR;
        run(FN_XOR, 4'hF, '{4'hF, 4'h0, 1'b1, 1'b0, 24}, 0);
        repeat (13) @(posedge clk);
        #1;
        check("dut_in_vec2", dut_in, 8'hAA);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_dut_in", dut_in, 0);
        check("abort_results", {bus.gate_pass, bus.gate_fail, bus.pass, bus.fail}, 0);
        check("abort_busy_done", {bus.busy, bus.done}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(FN_XOR, 4'hF, '{4'hF, 4'h0, 1'b1, 1'b0, 24}, 1);
        wait_idle();

        model_func = FN_OR;
        run(FN_OR, 4'hF, '{4'hF, 4'h0, 1'b1, 1'b0, 24}, 1);
        repeat (5) @(negedge clk);
        bus.start     = 1'b1;
        bus.gate_func = FN_AND;
        bus.gate_en   = 4'b0001;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.gate_func = FN_NOR;
        wait_idle();

        check("done_held", bus.done, 1);
        model_func = FN_AND;
        run(FN_AND, 4'hF, '{4'hF, 4'h0, 1'b1, 1'b0, 24}, 1);
        check("restart_clears_done", bus.done, 0);
        wait_idle();

        run(FN_XNOR, 4'h0, '{4'h0, 4'h0, 1'b0, 1'b0, 24}, 1);
        wait_idle();

        model_func = FN_XNOR;
        stuck0 = 4'b0001;
        run(FN_XNOR, 4'hF, '{4'b1110, 4'b0001, 1'b0, 1'b1, 24}, 1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
